// File: rtl/ultrasound_clk_reconfig_ctl.sv
// DRP reconfiguration sequencer for the ultrasound counter-clock MMCM: read-modify-write of
// DRP registers while the MMCM is held in reset, then release and wait for LOCKED.
module ultrasound_clk_reconfig_ctl #(
  parameter int RST_CYCLES   = 8,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  input  logic        cmd_last,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        lock_lost,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] RST_LIMIT  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] DRP_LIMIT  = CNT_W'(DRP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DRP  = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_HOLD  = 4'd1,
    S_RD        = 4'd2,
    S_RD_WAIT   = 4'd3,
    S_WR        = 4'd4,
    S_WR_WAIT   = 4'd5,
    S_CMD_WAIT  = 4'd6,
    S_RELEASE   = 4'd7,
    S_LOCK_WAIT = 4'd8,
    S_ABORT     = 4'd9
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [6:0]       addr_r;
  logic [15:0]      data_r;
  logic [15:0]      mask_r;
  logic             last_r;
  logic             rst_q_r;
  logic             locked_q_r;

  // Mask bit 1 keeps the value read back from the DRP, mask bit 0 takes the new value.
  function automatic logic [15:0] merge_bits(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [15:0] keep_m);
    return (old_v & keep_m) | (new_v & ~keep_m);
  endfunction

  assign mmcm_rst = reset | rst_q_r;

  // Sequencer state, timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      addr_r     <= 7'h00;
      data_r     <= 16'h0000;
      mask_r     <= 16'h0000;
      last_r     <= 1'b0;
      rst_q_r    <= 1'b0;
      locked_q_r <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_NONE;
      lock_lost  <= 1'b0;
      drp_den    <= 1'b0;
      drp_dwe    <= 1'b0;
      drp_daddr  <= 7'h00;
      drp_di     <= 16'h0000;
    end else begin
      drp_den    <= 1'b0;
      drp_dwe    <= 1'b0;
      done       <= 1'b0;
      locked_q_r <= mmcm_locked;
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_r    <= cmd_addr;
            data_r    <= cmd_data;
            mask_r    <= cmd_mask;
            last_r    <= cmd_last;
            err       <= ERR_NONE;
            lock_lost <= 1'b0;
            rst_q_r   <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            cnt_r     <= CNT_ONE;
            state_r   <= S_RST_HOLD;
          end else if (locked_q_r && !mmcm_locked) begin
            lock_lost <= 1'b1;
          end else begin
            lock_lost <= lock_lost;
          end
        end
        S_RST_HOLD: begin
          if (cnt_r == RST_LIMIT) begin
            drp_den   <= 1'b1;
            drp_daddr <= addr_r;
            state_r   <= S_RD;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_RD: begin
          cnt_r   <= CNT_ONE;
          state_r <= S_RD_WAIT;
        end
        // drdy on the expiry cycle still wins over the timeout.
        S_RD_WAIT: begin
          if (drp_drdy) begin
            drp_di  <= merge_bits(drp_do, data_r, mask_r);
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            state_r <= S_WR;
          end else if (cnt_r == DRP_LIMIT) begin
            err     <= ERR_DRP;
            rst_q_r <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_ABORT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_WR: begin
          cnt_r   <= CNT_ONE;
          state_r <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drp_drdy) begin
            if (last_r) begin
              rst_q_r <= 1'b0;
              state_r <= S_RELEASE;
            end else begin
              cmd_ready <= 1'b1;
              state_r   <= S_CMD_WAIT;
            end
          end else if (cnt_r == DRP_LIMIT) begin
            err     <= ERR_DRP;
            rst_q_r <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_ABORT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        // MMCM stays in reset between commands of one reconfiguration.
        S_CMD_WAIT: begin
          if (cmd_valid) begin
            addr_r    <= cmd_addr;
            data_r    <= cmd_data;
            mask_r    <= cmd_mask;
            last_r    <= cmd_last;
            cmd_ready <= 1'b0;
            drp_den   <= 1'b1;
            drp_daddr <= cmd_addr;
            state_r   <= S_RD;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_RELEASE: begin
          cnt_r   <= CNT_ONE;
          state_r <= S_LOCK_WAIT;
        end
        S_LOCK_WAIT: begin
          if (mmcm_locked) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= S_IDLE;
          end else if (cnt_r == LOCK_LIMIT) begin
            err     <= ERR_LOCK;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_ABORT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_ABORT: begin
          cmd_ready <= 1'b1;
          state_r   <= S_IDLE;
        end
        default: begin
          rst_q_r   <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasound_clk_reconfig_ctl.sv
// Self-checking bench: timeline model of the reconfiguration sequence compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ultrasound_clk_reconfig_ctl;

  localparam int RST_CYCLES   = 8;
  localparam int DRP_TIMEOUT  = 64;
  localparam int LOCK_TIMEOUT = 65536;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [6:0]  cmd_addr = 7'h00;
  logic [15:0] cmd_data = 16'h0000;
  logic [15:0] cmd_mask = 16'h0000;
  logic        cmd_last = 1'b0;
  logic        mmcm_locked = 1'b0;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_drdy = 1'b0;
  logic        cmd_ready, busy, done, lock_lost, mmcm_rst, drp_den, drp_dwe;
  logic [1:0]  err;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;

  ultrasound_clk_reconfig_ctl #(
    .RST_CYCLES(RST_CYCLES), .DRP_TIMEOUT(DRP_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_last(cmd_last),
    .busy(busy), .done(done), .err(err), .lock_lost(lock_lost), .mmcm_rst(mmcm_rst),
    .mmcm_locked(mmcm_locked), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr),
    .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endtask

  // ---------------- reference model (timeline of one reconfiguration) ----------------
  logic       exp_ready, exp_busy, exp_done, exp_lost, exp_rstq, exp_den, exp_dwe;
  logic [1:0] exp_err;
  logic [6:0] exp_daddr;
  logic [15:0] exp_di;
  bit         m_ab, m_fell;
  logic       m_lk_prev = 1'b0;
  logic [6:0] m_addr;
  logic [15:0] m_data, m_mask;
  logic       m_last;

  task automatic set_rst_vals();
    exp_ready = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 2'd0; exp_lost = 1'b0;
    exp_rstq = 1'b0; exp_den = 1'b0; exp_dwe = 1'b0; exp_daddr = 7'h00; exp_di = 16'h0000;
  endtask

  // One clock edge: inputs seen now decide the outputs of the following cycle.
  task automatic tick();
    @(posedge clk);
    exp_den = 1'b0; exp_dwe = 1'b0; exp_done = 1'b0;
    m_ab = reset;
    if (reset) begin
      set_rst_vals();
      m_fell = 1'b0;
      m_lk_prev = 1'b0;
    end else begin
      m_fell = m_lk_prev & ~mmcm_locked;
      m_lk_prev = mmcm_locked;
    end
  endtask

  task automatic capture();
    m_addr = cmd_addr; m_data = cmd_data; m_mask = cmd_mask; m_last = cmd_last;
  endtask

  // drdy counts during the DRP_TIMEOUT-1 cycles after the den cycle.
  task automatic drp_wait(output bit ok);
    ok = 1'b0;
    tick();
    if (m_ab) return;
    for (int k = 1; k < DRP_TIMEOUT; k++) begin
      tick();
      if (m_ab) return;
      if (drp_drdy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic abort_out(input logic [1:0] code);
    exp_err = code; exp_rstq = 1'b0; exp_done = 1'b1; exp_busy = 1'b0; exp_ready = 1'b0;
    tick();
    if (m_ab) return;
    exp_ready = 1'b1;
  endtask

  task automatic run_seq();
    bit ok;
    logic [15:0] rd;
    capture();
    exp_err = 2'd0; exp_lost = 1'b0; exp_rstq = 1'b1; exp_busy = 1'b1; exp_ready = 1'b0;
    repeat (RST_CYCLES) begin
      tick();
      if (m_ab) return;
    end
    forever begin
      exp_den = 1'b1; exp_daddr = m_addr;
      drp_wait(ok);
      if (m_ab) return;
      if (!ok) begin
        abort_out(2'd1);
        return;
      end
      rd = drp_do;
      exp_den = 1'b1; exp_dwe = 1'b1; exp_di = (rd & m_mask) | (m_data & ~m_mask);
      drp_wait(ok);
      if (m_ab) return;
      if (!ok) begin
        abort_out(2'd1);
        return;
      end
      if (m_last) break;
      exp_ready = 1'b1;
      do begin
        tick();
        if (m_ab) return;
      end while (!cmd_valid);
      capture();
      exp_ready = 1'b0;
    end
    exp_rstq = 1'b0;
    tick();
    if (m_ab) return;
    for (int k = 1; k < LOCK_TIMEOUT; k++) begin
      tick();
      if (m_ab) return;
      if (mmcm_locked) begin
        exp_done = 1'b1; exp_busy = 1'b0; exp_ready = 1'b1;
        return;
      end
    end
    abort_out(2'd2);
  endtask

  initial begin
    set_rst_vals();
    forever begin
      tick();
      if (!m_ab) begin
        if (cmd_valid) run_seq();
        else if (m_fell) exp_lost = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      chk("cmd_ready", int'(cmd_ready), int'(exp_ready));
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      chk("err", int'(err), int'(exp_err));
      chk("lock_lost", int'(lock_lost), int'(exp_lost));
      chk("mmcm_rst", int'(mmcm_rst), int'(reset | exp_rstq));
      chk("drp_den", int'(drp_den), int'(exp_den));
      chk("drp_dwe", int'(drp_dwe), int'(exp_dwe));
      if (exp_den) chk("drp_daddr", int'(drp_daddr), int'(exp_daddr));
      if (exp_den && exp_dwe) chk("drp_di", int'(drp_di), int'(exp_di));
    end
  end

  // ---------------- DRP slave and MMCM lock behaviour ----------------
  int resp_lat = 3;
  bit wr_hang = 1'b0;
  int dly = 0;
  initial forever begin
    @(negedge clk);
    drp_drdy = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) drp_drdy = 1'b1;
    end
    if (drp_den && resp_lat > 0 && !(drp_dwe && wr_hang)) dly = resp_lat;
  end

  int lock_lat = 5;
  bit lock_kill = 1'b0;
  int lcnt = 0;
  initial forever begin
    @(negedge clk);
    if (mmcm_rst || lock_kill) begin
      mmcm_locked = 1'b0;
      lcnt = lock_lat;
    end else if (!mmcm_locked && lcnt > 0) begin
      lcnt--;
      if (lcnt == 0) mmcm_locked = 1'b1;
    end
  end

  // ---------------- event monitor for hand-computed checks ----------------
  int den_cnt = 0, first_den_cyc = 0, last_den_cyc = 0, den_rst_low = 0;
  int done_cnt = 0, done_cyc = 0, rel_cyc = 0, acc_cyc = 0;
  logic [15:0] last_di = 16'h0000;
  logic rst_prev = 1'b1;
  initial forever begin
    @(negedge clk);
    #1;
    if (drp_den) begin
      if (den_cnt == 0) first_den_cyc = cyc;
      den_cnt++;
      last_den_cyc = cyc;
      if (drp_dwe) last_di = drp_di;
      if (!mmcm_rst) den_rst_low++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && rst_prev && !mmcm_rst) rel_cyc = cyc;
    rst_prev = mmcm_rst;
  end

  task automatic clear_mon();
    den_cnt = 0; den_rst_low = 0; last_di = 16'h0000;
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                          input logic l);
    int n;
    @(negedge clk);
    cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_last = l; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_within_bound", int'(cmd_ready), 1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_bound", int'(done_cnt != d0), 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int acc1;
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_mmcm_rst", int'(mmcm_rst), 1);
    chk("rst_drp_den", int'(drp_den), 0);
    chk("rst_drp_daddr", int'(drp_daddr), 0);
    chk("rst_drp_di", int'(drp_di), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // single command, read-back 0xFFFF
    drp_do = 16'hFFFF; resp_lat = 3; lock_lat = 5;
    clear_mon();
    send_cmd(7'h08, 16'h1041, 16'h1000, 1'b1);
    wait_done(500);
    chk("single_first_den_offset", first_den_cyc - acc_cyc, 9);
    chk("single_den_count", den_cnt, 2);
    chk("single_wr_di", int'(last_di), 32'h1041);
    chk("single_err", int'(err), 0);
    chk("single_busy_after", int'(busy), 0);
    repeat (5) @(negedge clk);

    // two commands, second one 20 cycles late
    drp_do = 16'h00F0;
    clear_mon();
    send_cmd(7'h08, 16'h1234, 16'hFF00, 1'b0);
    acc1 = acc_cyc;
    repeat (20) @(negedge clk);
    chk("cmdwait_ready", int'(cmd_ready), 1);
    chk("cmdwait_mmcm_rst", int'(mmcm_rst), 1);
    chk("cmdwait_first_di", int'(last_di), 32'h0034);
    send_cmd(7'h09, 16'hABCD, 16'h0F0F, 1'b1);
    wait_done(500);
    chk("two_first_den_offset", first_den_cyc - acc1, 9);
    chk("two_den_count", den_cnt, 4);
    chk("two_last_wr_di", int'(last_di), 32'hA0C0);
    chk("two_den_rst_low", den_rst_low, 0);
    repeat (5) @(negedge clk);

    // drdy exactly on the timeout-expiry cycle still succeeds
    drp_do = 16'hFFFF; resp_lat = 63;
    clear_mon();
    send_cmd(7'h0A, 16'h0000, 16'hFFFF, 1'b1);
    wait_done(1000);
    chk("late_drdy_err", int'(err), 0);
    chk("late_drdy_den_count", den_cnt, 2);
    chk("late_drdy_wr_di", int'(last_di), 32'hFFFF);
    repeat (5) @(negedge clk);

    // drdy never returned
    resp_lat = 0;
    clear_mon();
    send_cmd(7'h0B, 16'h5555, 16'h0000, 1'b1);
    wait_done(500);
    chk("drp_to_offset", done_cyc - last_den_cyc, 64);
    chk("drp_to_err", int'(err), 1);
    chk("drp_to_mmcm_rst", int'(mmcm_rst), 0);
    chk("drp_to_ready_next", int'(cmd_ready), 1);
    chk("drp_to_den_count", den_cnt, 1);
    repeat (10) @(negedge clk);

    // lock never arrives, then a new accept clears err
    resp_lat = 2; lock_lat = 0;
    clear_mon();
    send_cmd(7'h0C, 16'h0001, 16'hFFFE, 1'b1);
    wait_done(70000);
    chk("lock_to_offset", done_cyc - rel_cyc, 65536);
    chk("lock_to_err", int'(err), 2);
    repeat (3) @(negedge clk);
    lock_lat = 5;
    send_cmd(7'h0D, 16'h0002, 16'h0000, 1'b1);
    chk("err_cleared_on_accept", int'(err), 0);
    wait_done(500);
    chk("relock_err", int'(err), 0);
    repeat (5) @(negedge clk);

    // lock lost while idle is sticky
    chk("lock_lost_before", int'(lock_lost), 0);
    lock_kill = 1'b1;
    repeat (3) @(negedge clk);
    chk("lock_lost_set", int'(lock_lost), 1);
    repeat (10) @(negedge clk);
    chk("lock_lost_sticky", int'(lock_lost), 1);

    // reset while waiting for write completion
    lock_kill = 1'b0; resp_lat = 4; wr_hang = 1'b1;
    clear_mon();
    send_cmd(7'h0E, 16'h00FF, 16'hFF00, 1'b1);
    n = 0;
    while (den_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wr_issued", den_cnt, 2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_lock_lost", int'(lock_lost), 0);
    chk("midrst_drp_daddr", int'(drp_daddr), 0);
    chk("midrst_drp_di", int'(drp_di), 0);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    chk("no_den_after_reset", den_cnt, 2);
    wr_hang = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
